// File: rtl/cache_main_mem.sv
// Main-memory responder for the direct-mapped cache: fixed-latency block read/write.
// Optional MEM_STATS_EN adds saturating rd_count/wr_count commit counters.
module cache_main_mem #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned BLOCK_W    = 128,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  mem_req_addr,
    input  logic [BLOCK_W-1:0] mem_req_data,
    input  logic               mem_req_rw,
    input  logic               mem_req_valid,
    output logic [BLOCK_W-1:0] mem_data_data,
`ifdef MEM_STATS_EN
    output logic [31:0]        rd_count,
    output logic [31:0]        wr_count,
`endif
    output logic               mem_data_ready
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam int unsigned CntW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CntW-1:0] CntInit = CntW'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [BLOCK_W-1:0]      wdata_q, wdata_d;
    logic                    rw_q, rw_d;
    logic [BLOCK_W-1:0]      rdata_q, rdata_d;
    logic                    ready_q, ready_d;

    logic [BLOCK_W-1:0]      mem_q [Depth];

    logic [DEPTH_LOG2-1:0]   req_idx;
    logic                    commit;
    logic                    commit_rw;
    logic [DEPTH_LOG2-1:0]   commit_idx;
    logic [BLOCK_W-1:0]      commit_wdata;
    logic                    mem_we;
    logic                    do_rd;
    logic                    do_wr;

    // Upper address bits alias; byte offset within the block is irrelevant.
    logic unused_addr;
    assign unused_addr = ^{mem_req_addr[ADDR_W-1:DEPTH_LOG2+4], mem_req_addr[3:0]};
    assign req_idx     = mem_req_addr[DEPTH_LOG2+3:4];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        rw_d         = rw_q;
        ready_d      = 1'b0;
        commit       = 1'b0;
        commit_rw    = rw_q;
        commit_idx   = idx_q;
        commit_wdata = wdata_q;

        unique case (state_q)
            StIdle: begin
                if (mem_req_valid) begin
                    idx_d   = req_idx;
                    wdata_d = mem_req_data;
                    rw_d    = mem_req_rw;
                    cnt_d   = CntInit;
                    if (LATENCY == 1) begin
                        // Single-cycle latency commits straight from the live request.
                        state_d      = StResp;
                        ready_d      = 1'b1;
                        commit       = 1'b1;
                        commit_rw    = mem_req_rw;
                        commit_idx   = req_idx;
                        commit_wdata = mem_req_data;
                    end else begin
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    state_d = StResp;
                    ready_d = 1'b1;
                    commit  = 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        do_rd   = commit && !commit_rw;
        do_wr   = commit && commit_rw;
        mem_we  = do_wr;
        rdata_d = do_rd ? mem_q[commit_idx] : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

    // Array is never reset; a reset on the commit edge discards the write whole.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[commit_idx] <= commit_wdata;
        end
    end

    assign mem_data_data  = rdata_q;
    assign mem_data_ready = ready_q;

`ifdef MEM_STATS_EN
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (do_rd && (rd_count_q != 32'hFFFF_FFFF)) begin
            rd_count_d = rd_count_q + 32'd1;
        end
        if (do_wr && (wr_count_q != 32'hFFFF_FFFF)) begin
            wr_count_d = wr_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_cache_main_mem.sv
// Directed self-checking bench for cache_main_mem (LATENCY=4, DEPTH_LOG2=10).
module tb_cache_main_mem;

    logic         clk;
    logic         rst;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_data;
    logic         mem_req_rw;
    logic         mem_req_valid;
    logic [127:0] mem_data_data;
    logic         mem_data_ready;
`ifdef MEM_STATS_EN
    logic [31:0]  rd_count;
    logic [31:0]  wr_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_rd     = 0;
    int n_wr     = 0;

    localparam logic [127:0] PatP = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] PatA = {16{8'hA5}};
    localparam logic [127:0] PatF = {16{8'hFF}};
    localparam logic [127:0] PatO = {8{16'h1234}};
    localparam logic [127:0] PatQ = {4{32'hCAFE_0080}};
    localparam logic [127:0] PatR = {4{32'h0000_0040}};
    localparam logic [127:0] PatS = {4{32'h5A5A_0030}};
    localparam logic [127:0] PatJ = {4{32'hDEAD_BEEF}};

    cache_main_mem #(
        .ADDR_W     (32),
        .BLOCK_W    (128),
        .DEPTH_LOG2 (10),
        .LATENCY    (4)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_rw     (mem_req_rw),
        .mem_req_valid  (mem_req_valid),
        .mem_data_data  (mem_data_data),
`ifdef MEM_STATS_EN
        .rd_count       (rd_count),
        .wr_count       (wr_count),
`endif
        .mem_data_ready (mem_data_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction from IDLE: checks latency and one-cycle pulse, returns response data.
    task automatic xfer(input string tag, input logic [31:0] a, input logic [127:0] d,
                        input logic w, output logic [127:0] rd);
        int lat;
        mem_req_addr  = a;
        mem_req_data  = d;
        mem_req_rw    = w;
        mem_req_valid = 1'b1;
        @(posedge clk); #1;
        mem_req_valid = 1'b0;
        lat = 0;
        while (!mem_data_ready && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = mem_data_data;
        if (mem_data_ready) begin
            if (w) n_wr++;
            else   n_rd++;
        end
        check_val({tag, "_lat"}, 128'(lat), 128'd4);
        @(posedge clk); #1;
        check_val({tag, "_pulse"}, 128'(mem_data_ready), 128'd0);
    endtask

    // Write 0x20 with all-ones, reset sampled at edge E0+k; no pulse, no commit.
    task automatic rst_mid(input string tag, input int k);
        int seen;
        mem_req_addr  = 32'h20;
        mem_req_data  = PatF;
        mem_req_rw    = 1'b1;
        mem_req_valid = 1'b1;
        @(posedge clk); #1;
        mem_req_valid = 1'b0;
        seen = 0;
        repeat (k - 1) begin
            @(posedge clk); #1;
            if (mem_data_ready) seen++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        if (mem_data_ready) seen++;
        rst  = 1'b0;
        n_rd = 0;
        n_wr = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (mem_data_ready) seen++;
        end
        check_val({tag, "_noready"}, 128'(seen), 128'd0);
    endtask

    initial begin
        logic [127:0] rd;
        int t, t1, t2;

        // Reset held two cycles with a request pending.
        rst           = 1'b1;
        mem_req_addr  = 32'h0;
        mem_req_data  = '0;
        mem_req_rw    = 1'b1;
        mem_req_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_ready", 128'(mem_data_ready), 128'd0);
        check_val("rst_data", mem_data_data, 128'd0);
        rst = 1'b0;
        xfer("post_rst_wr", 32'h0, '0, 1'b1, rd);
        check_val("post_rst_data", rd, 128'd0);

        // Basic write then read.
        xfer("wr10", 32'h10, PatP, 1'b1, rd);
        check_val("wr10_data_held", rd, 128'd0);
        xfer("rd10", 32'h10, '0, 1'b0, rd);
        check_val("rd10_data", rd, PatP);

        // Back-to-back: write 0x40 then read 0x80 with valid held high.
        xfer("wr80", 32'h80, PatQ, 1'b1, rd);
        mem_req_addr  = 32'h40;
        mem_req_data  = PatR;
        mem_req_rw    = 1'b1;
        mem_req_valid = 1'b1;
        t = 0; t1 = -1; t2 = -1;
        while (t2 < 0 && t < 60) begin
            @(posedge clk); #1;
            t++;
            if (mem_data_ready) begin
                if (t1 < 0) begin
                    t1 = t;
                    n_wr++;
                    mem_req_addr = 32'h80;
                    mem_req_data = PatJ;
                    mem_req_rw   = 1'b0;
                end else begin
                    t2 = t;
                    rd = mem_data_data;
                    mem_req_valid = 1'b0;
                    n_rd++;
                end
            end
        end
        mem_req_valid = 1'b0;
        check_val("b2b_first", 128'(t1), 128'd5);
        check_val("b2b_gap", 128'(t2 - t1), 128'd6);
        check_val("b2b_data", rd, PatQ);
        @(posedge clk); #1;
        xfer("rd40", 32'h40, '0, 1'b0, rd);
        check_val("rd40_data", rd, PatR);

        // Aliasing across the 2^10-block boundary.
        xfer("wr_alias", 32'h0000_0010, PatA, 1'b1, rd);
        xfer("rd_alias", 32'h0000_4010, '0, 1'b0, rd);
        check_val("alias_data", rd, PatA);

        // Reset mid-operation, in BUSY and on the commit edge.
        xfer("wr20_old", 32'h20, PatO, 1'b1, rd);
        rst_mid("rst_busy2", 2);
        xfer("rd20_a", 32'h20, '0, 1'b0, rd);
        check_val("rst_busy2_data", rd, PatO);
        rst_mid("rst_commit", 4);
        xfer("rd20_b", 32'h20, '0, 1'b0, rd);
        check_val("rst_commit_data", rd, PatO);

        // Request inputs changing during BUSY are ignored.
        xfer("wr30", 32'h30, PatS, 1'b1, rd);
        mem_req_addr  = 32'h30;
        mem_req_rw    = 1'b0;
        mem_req_valid = 1'b1;
        @(posedge clk); #1;
        mem_req_addr = 32'h10;
        mem_req_rw   = 1'b1;
        mem_req_data = PatJ;
        @(posedge clk); #1;
        mem_req_valid = 1'b0;
        t = 1;
        while (!mem_data_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (mem_data_ready) n_rd++;
        check_val("stab_lat", 128'(t), 128'd4);
        check_val("stab_data", mem_data_data, PatS);
        @(posedge clk); #1;
        xfer("rd10_stab", 32'h10, '0, 1'b0, rd);
        check_val("stab_no_wr", rd, PatA);

`ifdef MEM_STATS_EN
        check_val("rd_count", 128'(rd_count), 128'(n_rd));
        check_val("wr_count", 128'(wr_count), 128'(n_wr));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
